// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   UART receive stage. Oversamples the serial line, deserializes one frame at a time
//   (start, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits) and presents the
//   word plus its error flags through a single holding register with a valid/ready
//   handshake.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-low reset
//   rx              asynchronous serial line, idle high
//   cfgDivisor      clocks per oversample tick (0 behaves as 1)
//   cfgOverSampling ticks per bit: 13, anything else runs at 16
//   cfgDataType     data bits per frame 5..8, other values mean 8
//   cfgParityEnable 1 = parity bit follows the data bits
//   cfgParityType   0 = even, 1 = odd
//   cfgStopBits     2 = two stop bits, anything else means one
//   rxData          held word, unused upper bits are 0
//   rxParity        parity bit as sampled (0 when parity is disabled)
//   rxValid         holding register is full
//   rxReady         consumer takes the held word
//   parityError     parity mismatch on the held word
//   framingError    a stop bit of the held word was sampled as 0
//   breakError      the held word was a break (line low for the whole frame)
//   overrunError    a frame was dropped while the word was held
//   busy            receiver is not idle
//
// DATA_WIDTH is expected to be at least 8 so that every supported frame size fits.
module uart_rx_deserializer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   input  logic [DIV_WIDTH-1:0]  cfgDivisor,
   input  logic [4:0]            cfgOverSampling,
   input  logic [3:0]            cfgDataType,
   input  logic                  cfgParityEnable,
   input  logic                  cfgParityType,
   input  logic [1:0]            cfgStopBits,
   output logic [DATA_WIDTH-1:0] rxData,
   output logic                  rxParity,
   output logic                  rxValid,
   input  logic                  rxReady,
   output logic                  parityError,
   output logic                  framingError,
   output logic                  breakError,
   output logic                  overrunError,
   output logic                  busy
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreakWait
   } state_e;

   // Line synchronizer and edge detect
   logic                  rx_meta_q;
   logic                  rxs_q;
   logic                  rxs_prev_q;

   // Frame state
   state_e                state_q;
   logic [DIV_WIDTH-1:0]  div_cnt_q;
   logic [DIV_WIDTH-1:0]  div_last_q;
   logic [4:0]            tick_cnt_q;
   logic [4:0]            os_q;
   logic [3:0]            nbits_q;
   logic                  par_en_q;
   logic                  par_odd_q;
   logic [1:0]            nstop_q;
   logic [3:0]            bit_idx_q;
   logic [1:0]            stop_idx_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  par_bit_q;
   logic                  par_err_q;
   logic                  frm_err_q;
   logic                  brk_q;
   logic                  all_zero_q;
   logic                  done_q;

   // Holding register
   logic [DATA_WIDTH-1:0] hold_data_q;
   logic                  hold_par_q;
   logic                  hold_valid_q;
   logic                  hold_perr_q;
   logic                  hold_ferr_q;
   logic                  hold_berr_q;
   logic                  hold_ovr_q;

   // Decoded configuration, only consumed at the start edge
   logic [DIV_WIDTH-1:0]  cfg_div_last;
   logic [4:0]            cfg_os;
   logic [3:0]            cfg_nbits;
   logic [1:0]            cfg_nstop;

   logic                  start_det;
   logic                  tick;
   logic                  half_pt;
   logic                  full_pt;
   logic                  exp_parity;

   assign cfg_div_last = (cfgDivisor == '0) ? '0 : cfgDivisor - DIV_WIDTH'(1);
   assign cfg_os       = (cfgOverSampling == 5'd13) ? 5'd13 : 5'd16;
   assign cfg_nbits    = (cfgDataType >= 4'd5 && cfgDataType <= 4'd8) ? cfgDataType : 4'd8;
   assign cfg_nstop    = (cfgStopBits == 2'd2) ? 2'd2 : 2'd1;

   assign start_det  = (state_q == StIdle) && rxs_prev_q && !rxs_q;
   assign tick       = (div_cnt_q == div_last_q);
   // Start bit is checked at its middle; every later bit a full bit time after that.
   assign half_pt    = (tick_cnt_q == ((os_q >> 1) - 5'd1));
   assign full_pt    = (tick_cnt_q == (os_q - 5'd1));
   // Unused upper bits of shift_q are zero, so they do not disturb the XOR.
   assign exp_parity = (^shift_q) ^ par_odd_q;

   assign busy = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
         state_q    <= StIdle;
         div_cnt_q  <= '0;
         div_last_q <= '0;
         tick_cnt_q <= '0;
         os_q       <= 5'd16;
         nbits_q    <= 4'd8;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         nstop_q    <= 2'd1;
         bit_idx_q  <= '0;
         stop_idx_q <= '0;
         shift_q    <= '0;
         par_bit_q  <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         brk_q      <= 1'b0;
         all_zero_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rx_meta_q  <= rx;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
         done_q     <= 1'b0;

         // Restarting the divider on the start edge aligns ticks to the frame.
         if (start_det || tick) begin
            div_cnt_q <= '0;
         end else begin
            div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
         end

         case (state_q)
            StIdle: begin
               if (start_det) begin
                  state_q    <= StStart;
                  tick_cnt_q <= '0;
                  div_last_q <= cfg_div_last;
                  os_q       <= cfg_os;
                  nbits_q    <= cfg_nbits;
                  par_en_q   <= cfgParityEnable;
                  par_odd_q  <= cfgParityType;
                  nstop_q    <= cfg_nstop;
                  bit_idx_q  <= '0;
                  stop_idx_q <= '0;
                  shift_q    <= '0;
                  par_bit_q  <= 1'b0;
                  par_err_q  <= 1'b0;
                  frm_err_q  <= 1'b0;
                  brk_q      <= 1'b0;
                  all_zero_q <= 1'b1;
               end
            end

            StStart: begin
               if (tick) begin
                  if (half_pt) begin
                     tick_cnt_q <= '0;
                     // A high line at mid start bit is a glitch, not a frame.
                     state_q    <= rxs_q ? StIdle : StData;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 5'd1;
                  end
               end
            end

            StData: begin
               if (tick) begin
                  if (full_pt) begin
                     tick_cnt_q <= '0;
                     shift_q    <= shift_q | (DATA_WIDTH'(rxs_q) << bit_idx_q);
                     if (rxs_q) begin
                        all_zero_q <= 1'b0;
                     end
                     if (bit_idx_q == (nbits_q - 4'd1)) begin
                        state_q <= par_en_q ? StParity : StStop;
                     end else begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 5'd1;
                  end
               end
            end

            StParity: begin
               if (tick) begin
                  if (full_pt) begin
                     tick_cnt_q <= '0;
                     par_bit_q  <= rxs_q;
                     par_err_q  <= rxs_q ^ exp_parity;
                     if (rxs_q) begin
                        all_zero_q <= 1'b0;
                     end
                     state_q <= StStop;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 5'd1;
                  end
               end
            end

            StStop: begin
               if (tick) begin
                  if (full_pt) begin
                     tick_cnt_q <= '0;
                     if (!rxs_q) begin
                        frm_err_q <= 1'b1;
                     end else begin
                        all_zero_q <= 1'b0;
                     end
                     if (stop_idx_q == (nstop_q - 2'd1)) begin
                        done_q  <= 1'b1;
                        brk_q   <= all_zero_q && !rxs_q;
                        // After a break, wait for the line to recover before
                        // looking for another start edge.
                        state_q <= (all_zero_q && !rxs_q) ? StBreakWait : StIdle;
                     end else begin
                        stop_idx_q <= stop_idx_q + 2'd1;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 5'd1;
                  end
               end
            end

            StBreakWait: begin
               if (rxs_q) begin
                  state_q <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Holding register: a completed frame is accepted when the register is empty or is
   // being drained in the same cycle; otherwise it is dropped and flagged as overrun.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_data_q  <= '0;
         hold_par_q   <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_perr_q  <= 1'b0;
         hold_ferr_q  <= 1'b0;
         hold_berr_q  <= 1'b0;
         hold_ovr_q   <= 1'b0;
      end else if (done_q) begin
         if (!hold_valid_q || rxReady) begin
            hold_data_q  <= shift_q;
            hold_par_q   <= par_bit_q;
            hold_valid_q <= 1'b1;
            hold_perr_q  <= par_err_q;
            hold_ferr_q  <= frm_err_q;
            hold_berr_q  <= brk_q;
            hold_ovr_q   <= 1'b0;
         end else begin
            hold_ovr_q <= 1'b1;
         end
      end else if (hold_valid_q && rxReady) begin
         hold_valid_q <= 1'b0;
         hold_perr_q  <= 1'b0;
         hold_ferr_q  <= 1'b0;
         hold_berr_q  <= 1'b0;
         hold_ovr_q   <= 1'b0;
      end
   end

   assign rxData       = hold_data_q;
   assign rxParity     = hold_par_q;
   assign rxValid      = hold_valid_q;
   assign parityError  = hold_perr_q;
   assign framingError = hold_ferr_q;
   assign breakError   = hold_berr_q;
   assign overrunError = hold_ovr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer: a vector table of complete frames, hand-written
// sequences for false start, overrun, completion-with-ready, break and mid-frame reset,
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_deserializer;
   localparam int DW   = 8;
   localparam int DIVW = 16;

   logic            clk;
   logic            reset;
   logic            rx;
   logic [DIVW-1:0] cfgDivisor;
   logic [4:0]      cfgOverSampling;
   logic [3:0]      cfgDataType;
   logic            cfgParityEnable;
   logic            cfgParityType;
   logic [1:0]      cfgStopBits;
   logic [DW-1:0]   rxData;
   logic            rxParity;
   logic            rxValid;
   logic            rxReady;
   logic            parityError;
   logic            framingError;
   logic            breakError;
   logic            overrunError;
   logic            busy;

   int n_checks;
   int n_errors;
   int bit_clks;

   typedef struct {
      int         div;
      int         os;
      int         dtype;
      bit         pen;
      bit         podd;
      int         stp;
      logic [7:0] data;
      int         nd;
      bit         pbit;
      int         ns;
      logic [1:0] sb;
      logic [7:0] e_data;
      bit         e_par;
      bit         e_perr;
      bit         e_ferr;
      bit         e_berr;
   } vec_t;

   vec_t vecs[9];

   uart_rx_deserializer #(
      .DATA_WIDTH(DW),
      .DIV_WIDTH (DIVW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rx             (rx),
      .cfgDivisor     (cfgDivisor),
      .cfgOverSampling(cfgOverSampling),
      .cfgDataType    (cfgDataType),
      .cfgParityEnable(cfgParityEnable),
      .cfgParityType  (cfgParityType),
      .cfgStopBits    (cfgStopBits),
      .rxData         (rxData),
      .rxParity       (rxParity),
      .rxValid        (rxValid),
      .rxReady        (rxReady),
      .parityError    (parityError),
      .framingError   (framingError),
      .breakError     (breakError),
      .overrunError   (overrunError),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_cfg(input int div, input int os, input int dtype, input bit pen,
                          input bit podd, input int stp);
      cfgDivisor      = DIVW'(div);
      cfgOverSampling = 5'(os);
      cfgDataType     = 4'(dtype);
      cfgParityEnable = pen;
      cfgParityType   = podd;
      cfgStopBits     = 2'(stp);
      bit_clks        = os * ((div == 0) ? 1 : div);
   endtask

   task automatic scramble_cfg();
      cfgDivisor      = DIVW'($urandom);
      cfgOverSampling = 5'($urandom);
      cfgDataType     = 4'($urandom);
      cfgParityEnable = 1'($urandom);
      cfgParityType   = 1'($urandom);
      cfgStopBits     = 2'($urandom);
   endtask

   task automatic idle(input int nbits);
      rx = 1'b1;
      tick_n(nbits * bit_clks);
   endtask

   // Plays start, nd data bits (LSB first), optional parity and ns stop bits.
   task automatic send_frame(input logic [7:0] data, input int nd, input bit pen,
                             input bit pbit, input int ns, input logic [1:0] sb,
                             input bit scramble, input int last_clks);
      logic       seq[$];
      logic [7:0] d;
      logic [1:0] s;
      d = data;
      s = sb;
      seq.push_back(1'b0);
      for (int i = 0; i < nd; i++) begin
         seq.push_back(d[0]);
         d = d >> 1;
      end
      if (pen) seq.push_back(pbit);
      for (int i = 0; i < ns; i++) begin
         seq.push_back(s[0]);
         s = s >> 1;
      end
      for (int i = 0; i < seq.size(); i++) begin
         rx = seq[i];
         if (scramble && i == 2) scramble_cfg();
         tick_n((i == seq.size() - 1) ? last_clks : bit_clks);
      end
      rx = 1'b1;
   endtask

   task automatic check_word(input string name, input int e_data, input int e_par,
                             input int e_perr, input int e_ferr, input int e_berr,
                             input int e_ovr);
      check({name, ".valid"},   32'(rxValid),      32'd1);
      check({name, ".data"},    32'(rxData),       32'(e_data));
      check({name, ".parity"},  32'(rxParity),     32'(e_par));
      check({name, ".perr"},    32'(parityError),  32'(e_perr));
      check({name, ".ferr"},    32'(framingError), 32'(e_ferr));
      check({name, ".break"},   32'(breakError),   32'(e_berr));
      check({name, ".overrun"}, 32'(overrunError), 32'(e_ovr));
   endtask

   task automatic consume(input string name);
      rxReady = 1'b1;
      tick_n(1);
      rxReady = 1'b0;
      check({name, ".drained"},   32'(rxValid),      32'd0);
      check({name, ".perr_clr"},  32'(parityError),  32'd0);
      check({name, ".ferr_clr"},  32'(framingError), 32'd0);
      check({name, ".brk_clr"},   32'(breakError),   32'd0);
      check({name, ".ovr_clr"},   32'(overrunError), 32'd0);
   endtask

   // Frame-level model: what the receiver must report for a frame put on the line.
   function automatic void ref_frame(input logic [7:0] data, input int dtype, input bit pen,
                                     input bit podd, input bit pbit, input int stp,
                                     input logic [1:0] sb, output logic [7:0] e_data,
                                     output bit e_par, output bit e_perr, output bit e_ferr,
                                     output bit e_berr);
      int n;
      int ns;
      bit want_par;
      bit stops_low;
      n         = (dtype >= 5 && dtype <= 8) ? dtype : 8;
      ns        = (stp == 2) ? 2 : 1;
      e_data    = data & 8'((1 << n) - 1);
      want_par  = (($countones(e_data) % 2) == 1) ^ podd;
      e_par     = pen ? pbit : 1'b0;
      e_perr    = pen && (pbit != want_par);
      e_ferr    = (sb[0] == 1'b0) || (ns == 2 && sb[1] == 1'b0);
      stops_low = (sb[0] == 1'b0) && (ns == 1 || sb[1] == 1'b0);
      e_berr    = (e_data == 8'h00) && (!pen || !pbit) && stops_low;
   endfunction

   initial begin
      bit found;
      n_checks = 0;
      n_errors = 0;

      //          div os dt pen odd stp data  nd pb ns sb     e_data e_par perr ferr berr
      vecs[0] = '{4, 16, 8, 1, 0, 1, 8'hA5, 8, 0, 1, 2'b11, 8'hA5, 0, 0, 0, 0};
      vecs[1] = '{4, 16, 8, 1, 1, 1, 8'hA5, 8, 0, 1, 2'b11, 8'hA5, 0, 1, 0, 0};
      vecs[2] = '{4, 16, 5, 0, 0, 2, 8'h1F, 5, 0, 2, 2'b11, 8'h1F, 0, 0, 0, 0};
      vecs[3] = '{0, 13, 7, 1, 1, 2, 8'h5A, 7, 1, 2, 2'b11, 8'h5A, 1, 0, 0, 0};
      vecs[4] = '{2, 16, 6, 1, 0, 0, 8'h2B, 6, 1, 1, 2'b11, 8'h2B, 1, 1, 0, 0};
      vecs[5] = '{3, 16, 15, 0, 0, 1, 8'hC3, 8, 0, 1, 2'b10, 8'hC3, 0, 0, 1, 0};
      vecs[6] = '{1, 13, 8, 1, 0, 2, 8'h00, 8, 0, 2, 2'b00, 8'h00, 0, 0, 1, 1};
      vecs[7] = '{3, 13, 5, 1, 1, 3, 8'h15, 5, 0, 1, 2'b11, 8'h15, 0, 0, 0, 0};
      vecs[8] = '{1, 16, 3, 1, 0, 1, 8'hF0, 8, 1, 1, 2'b11, 8'hF0, 1, 1, 0, 0};

      // Reset state
      reset   = 1'b0;
      rx      = 1'b1;
      rxReady = 1'b0;
      set_cfg(4, 16, 8, 1, 0, 1);
      tick_n(4);
      check("reset.valid",   32'(rxValid),      32'd0);
      check("reset.data",    32'(rxData),       32'd0);
      check("reset.parity",  32'(rxParity),     32'd0);
      check("reset.flags",   32'({parityError, framingError, breakError, overrunError}), 32'd0);
      check("reset.busy",    32'(busy),         32'd0);
      reset = 1'b1;
      idle(2);

      // Vector table
      for (int i = 0; i < 9; i++) begin
         set_cfg(vecs[i].div, vecs[i].os, vecs[i].dtype, vecs[i].pen, vecs[i].podd,
                 vecs[i].stp);
         idle(2);
         send_frame(vecs[i].data, vecs[i].nd, vecs[i].pen, vecs[i].pbit, vecs[i].ns,
                    vecs[i].sb, 1'b0, bit_clks);
         idle(2);
         check_word($sformatf("vec%0d", i), 32'(vecs[i].e_data), 32'(vecs[i].e_par),
                    32'(vecs[i].e_perr), 32'(vecs[i].e_ferr), 32'(vecs[i].e_berr), 0);
         tick_n(7);
         check($sformatf("vec%0d.held", i), 32'({rxValid, rxData}),
               32'({1'b1, vecs[i].e_data}));
         consume($sformatf("vec%0d", i));
      end

      // False start: 20-clock low pulse is gone by the mid-start-bit sample
      set_cfg(4, 16, 8, 1, 0, 1);
      idle(2);
      rx = 1'b0;
      tick_n(20);
      rx = 1'b1;
      tick_n(3 * bit_clks);
      check("false_start.valid", 32'(rxValid), 32'd0);
      check("false_start.busy",  32'(busy),    32'd0);
      send_frame(8'h3C, 8, 1'b1, 1'b0, 1, 2'b11, 1'b0, bit_clks);
      idle(2);
      check_word("after_false", 32'h3C, 0, 0, 0, 0, 0);
      consume("after_false");

      // Overrun: second frame dropped while the first is held
      send_frame(8'h11, 8, 1'b1, 1'b0, 1, 2'b11, 1'b0, bit_clks);
      idle(2);
      send_frame(8'h22, 8, 1'b1, 1'b0, 1, 2'b11, 1'b0, bit_clks);
      idle(2);
      check_word("overrun", 32'h11, 0, 0, 0, 0, 1);
      consume("overrun");

      // Completion in the same cycle as rxReady on a held word
      send_frame(8'h33, 8, 1'b1, 1'b0, 1, 2'b11, 1'b0, bit_clks);
      idle(2);
      check_word("coincide.first", 32'h33, 0, 0, 0, 0, 0);
      send_frame(8'h44, 8, 1'b1, 1'b0, 1, 2'b11, 1'b0, 0);
      found = 1'b0;
      for (int c = 0; c < 2 * bit_clks && !found; c++) begin
         tick_n(1);
         if (!busy) found = 1'b1;
      end
      check("coincide.busy_fall", 32'(found), 32'd1);
      rxReady = 1'b1;
      tick_n(1);
      rxReady = 1'b0;
      check("coincide.valid",   32'(rxValid),      32'd1);
      check("coincide.data",    32'(rxData),       32'h44);
      check("coincide.overrun", 32'(overrunError), 32'd0);
      idle(2);
      consume("coincide");

      // Break: line low for 12 bit times
      rx = 1'b0;
      tick_n(12 * bit_clks);
      check_word("break", 32'h00, 0, 0, 1, 1, 0);
      check("break.wait_busy", 32'(busy), 32'd1);
      consume("break");
      tick_n(bit_clks);
      check("break.no_new", 32'(rxValid), 32'd0);
      idle(2);
      check("break.idle", 32'(busy), 32'd0);
      send_frame(8'h55, 8, 1'b1, 1'b0, 1, 2'b11, 1'b0, bit_clks);
      idle(2);
      check_word("after_break", 32'h55, 0, 0, 0, 0, 0);

      // Reset mid-data of 0x96 while 0x55 is still held; sender then abandons the frame
      rx = 1'b0;
      tick_n(bit_clks);
      rx = 1'b0;
      tick_n(bit_clks);
      rx = 1'b1;
      tick_n(bit_clks);
      tick_n(bit_clks / 2);
      check("midreset.busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      tick_n(1);
      reset = 1'b1;
      check("midreset.valid",  32'(rxValid),  32'd0);
      check("midreset.data",   32'(rxData),   32'd0);
      check("midreset.parity", 32'(rxParity), 32'd0);
      check("midreset.flags",  32'({parityError, framingError, breakError, overrunError}),
            32'd0);
      check("midreset.busy",   32'(busy),     32'd0);
      idle(4);
      check("midreset.no_word", 32'(rxValid), 32'd0);
      send_frame(8'h69, 8, 1'b1, 1'b0, 1, 2'b11, 1'b0, bit_clks);
      idle(2);
      check_word("after_reset", 32'h69, 0, 0, 0, 0, 0);
      consume("after_reset");

      // Randomized frames, config scrambled mid-frame on some of them
      for (int f = 0; f < 30; f++) begin
         int         div;
         int         os;
         int         dtype;
         int         stp;
         int         nd;
         int         ns;
         bit         pen;
         bit         podd;
         bit         pbit;
         bit         scr;
         logic [7:0] data;
         logic [1:0] sb;
         logic [7:0] e_data;
         bit         e_par;
         bit         e_perr;
         bit         e_ferr;
         bit         e_berr;
         div   = $urandom_range(0, 3);
         os    = ($urandom_range(0, 1) == 0) ? 13 : 16;
         dtype = $urandom_range(0, 15);
         pen   = 1'($urandom);
         podd  = 1'($urandom);
         stp   = $urandom_range(0, 3);
         data  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         pbit  = pen ? 1'($urandom) : 1'b0;
         sb    = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
         scr   = 1'($urandom);
         nd    = (dtype >= 5 && dtype <= 8) ? dtype : 8;
         ns    = (stp == 2) ? 2 : 1;
         ref_frame(data, dtype, pen, podd, pbit, stp, sb, e_data, e_par, e_perr, e_ferr,
                   e_berr);
         set_cfg(div, os, dtype, pen, podd, stp);
         idle(2);
         send_frame(data, nd, pen, pbit, ns, sb, scr, bit_clks);
         idle(2);
         check_word($sformatf("rand%0d", f), 32'(e_data), 32'(e_par), 32'(e_perr),
                    32'(e_ferr), 32'(e_berr), 0);
         consume($sformatf("rand%0d", f));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion",
               n_checks);
      $fatal(1, "watchdog");
   end

endmodule
